// File: rtl/mi_nios_pkg.sv
// Shared system constants for the Nios board support logic, plus the helper
// that turns a debounce time in milliseconds into a clock-cycle count.
package mi_nios_pkg;

  // Number of slide switches routed to the switch PIO.
  localparam int SW_WIDTH = 4;

  // System clock frequency shared by the PIO slave and the switch conditioner.
  localparam int CLK_HZ = 50000000;

  // Time a switch must sit at a new level before it is believed.
  localparam int SW_DEBOUNCE_MS = 10;

  // Clock cycles in ms milliseconds at clk_hz. A zero result is bumped to 1
  // so a very slow clock or a zero time still yields a legal debounce depth.
  function automatic int debounce_cycles(input int clk_hz, input int ms);
    int cycles;
    cycles = (clk_hz / 1000) * ms;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/mi_nios_debounce_bit.sv
// Single-bit switch conditioner: synchroniser chain, stability counter and
// registered clean level with a one-cycle change pulse.
module mi_nios_debounce_bit
  import mi_nios_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, SW_DEBOUNCE_MS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_changed
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard against illegal parameterisations.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mi_nios_debounce_bit: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("mi_nios_debounce_bit: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_bit;
  logic [CNT_W-1:0]       cnt_p1;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   mismatch;
  logic                   expire;
  logic                   clean_p1;
  logic                   changed_p1;

  // Advance the stability count; the terminal value folds back to zero so
  // the counter can never wrap past DEBOUNCE_CYCLES-1.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? '0 : c + CNT_W'(1);
  endfunction

  // ---- stage p0: synchroniser, pure flop chain with nothing between stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sync_bit = sync_p0[SYNC_STAGES-1];

  // ---- stage p1: compare against the accepted level and decide on a flip
  // Next count and flip decision from the synchronised level vs. clean level.
  always_comb begin
    mismatch = sync_bit ^ clean_p1;
    expire   = mismatch && (cnt_p1 == CNT_LAST);
    cnt_nxt  = mismatch ? cnt_step(cnt_p1) : '0;
  end

  // Stability counter; any return to match restarts the measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_nxt;
    end
  end

  // Clean level and change pulse update together on the expiring edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_p1   <= 1'b0;
      changed_p1 <= 1'b0;
    end else begin
      if (expire) begin
        clean_p1 <= sync_bit;
      end
      changed_p1 <= expire;
    end
  end

  assign sw_clean   = clean_p1;
  assign sw_changed = changed_p1;

endmodule

// File: rtl/mi_nios_sw_debounce.sv
// Slide-switch conditioner in front of the switch PIO in_port: every pin is
// synchronised and debounced independently, giving a clean level vector and
// per-bit one-cycle change pulses. All outputs are registered.
module mi_nios_sw_debounce
  import mi_nios_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, SW_DEBOUNCE_MS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mi_nios_sw_debounce: WIDTH must be at least 1");
  end

  // One independent conditioner per switch; simultaneous toggles on several
  // pins therefore produce simultaneous pulses.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mi_nios_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw[i]),
      .sw_clean   (sw_clean[i]),
      .sw_changed (sw_changed[i])
    );
  end

endmodule

// File: tb/tb_mi_nios_sw_debounce.sv
// Bench for mi_nios_sw_debounce with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
// Reference model: a raw-sample delay line feeding a window of the last D
// synchronised samples; a bit flips when every sample in the window disagrees
// with its current clean level.
module tb_mi_nios_sw_debounce;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_changed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_sync [S];
  logic [W-1:0] m_hist [D];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_chg;

  always #5 clk = ~clk;

  mi_nios_sw_debounce #(
    .WIDTH           (W),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < S; j++) m_sync[j] = '0;
    for (int j = 0; j < D; j++) m_hist[j] = '0;
    m_clean = '0;
    m_chg   = '0;
  endtask

  // One rising edge of the reference: the synchronised value seen by this
  // edge enters the window, then the delay line takes the raw pin sample.
  task automatic model_edge();
    logic [W-1:0] all_mis;
    for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_sync[S-1];
    all_mis = '1;
    for (int j = 0; j < D; j++) all_mis &= (m_hist[j] ^ m_clean);
    m_chg   = all_mis;
    m_clean = m_clean ^ all_mis;
    for (int j = S - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
    m_sync[0] = sw_raw;
  endtask

  // Advance one clock, update the model, compare both outputs after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) model_edge();
    else         model_reset();
    #1;
    chk({tag, "_clean"}, sw_clean, m_clean);
    chk({tag, "_chg"}, sw_changed, m_chg);
  endtask

  // Run n steps, recording the first step (1-based) and number of pulses on mask.
  task automatic run_watch(input string tag, input int n, input logic [W-1:0] mask,
                           output int first_edge, output int pulses);
    first_edge = 0;
    pulses     = 0;
    for (int k = 1; k <= n; k++) begin
      step(tag);
      if ((sw_changed & mask) != '0) begin
        pulses++;
        if (first_edge == 0) first_edge = k;
      end
    end
  endtask

  initial begin
    int f1, p1, f2, p2, f3, p3;
    logic [W-1:0] tmask;
    int rst_left;

    // 1: reset with all switches high
    model_reset();
    reset_n = 1'b0;
    sw_raw  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step("t1_in_reset");
      chk("t1_rst_clean", sw_clean, 4'h0);
      chk("t1_rst_chg", sw_changed, 4'h0);
    end
    reset_n = 1'b1;
    run_watch("t1", 9, 4'hF, f1, p1);
    chk_int("t1_early_pulses", p1, 0);
    chk("t1_edge9_clean", sw_clean, 4'h0);
    step("t1");
    chk("t1_edge10_clean", sw_clean, 4'hF);
    chk("t1_edge10_chg", sw_changed, 4'hF);
    run_watch("t1_after", 3, 4'hF, f1, p1);
    chk_int("t1_after_pulses", p1, 0);

    // 2: clean single-bit step
    sw_raw = 4'h0;
    run_watch("t2_settle", 12, 4'hF, f1, p1);
    chk("t2_settled", sw_clean, 4'h0);
    sw_raw = 4'h1;
    run_watch("t2", 14, 4'hF, f1, p1);
    chk_int("t2_first_edge", f1, 10);
    chk_int("t2_pulses", p1, 1);
    chk("t2_clean", sw_clean, 4'h1);

    // 3: bounce on bit1
    sw_raw = 4'h3;
    run_watch("t3_hi", 5, 4'h2, f1, p1);
    sw_raw = 4'h1;
    run_watch("t3_lo", 2, 4'h2, f2, p2);
    sw_raw = 4'h3;
    run_watch("t3_stable", 14, 4'h2, f3, p3);
    chk_int("t3_bounce_pulses", p1 + p2, 0);
    chk_int("t3_first_edge", f3, 10);
    chk_int("t3_pulses", p3, 1);
    chk("t3_clean", sw_clean, 4'h3);

    // 4: glitch on bit2 shorter than the debounce window
    sw_raw = 4'h7;
    run_watch("t4_hi", 7, 4'h4, f1, p1);
    sw_raw = 4'h3;
    run_watch("t4_lo", 13, 4'h4, f2, p2);
    chk_int("t4_pulses", p1 + p2, 0);
    chk("t4_clean", sw_clean, 4'h3);

    // 5: simultaneous toggles
    sw_raw = 4'h0;
    run_watch("t5_settle", 12, 4'hF, f1, p1);
    sw_raw = 4'hA;
    run_watch("t5_a", 9, 4'hF, f1, p1);
    chk_int("t5_a_early", p1, 0);
    step("t5_a");
    chk("t5_a_clean", sw_clean, 4'hA);
    chk("t5_a_chg", sw_changed, 4'hA);
    run_watch("t5_a_hold", 2, 4'hF, f1, p1);
    sw_raw = 4'h5;
    run_watch("t5_5", 9, 4'hF, f1, p1);
    chk_int("t5_5_early", p1, 0);
    step("t5_5");
    chk("t5_5_clean", sw_clean, 4'h5);
    chk("t5_5_chg", sw_changed, 4'hF);

    // 6: reset asserted mid-count
    sw_raw = 4'h0;
    run_watch("t6_settle", 12, 4'hF, f1, p1);
    sw_raw = 4'h8;
    run_watch("t6_count", 7, 4'hF, f1, p1);
    chk_int("t6_count_pulses", p1, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_clean", sw_clean, 4'h0);
    chk("t6_async_chg", sw_changed, 4'h0);
    step("t6_in_reset");
    step("t6_in_reset");
    reset_n = 1'b1;
    run_watch("t6_release", 12, 4'h8, f1, p1);
    chk_int("t6_first_edge", f1, 10);
    chk_int("t6_pulses", p1, 1);
    chk("t6_clean", sw_clean, 4'h8);

    // Random: fast bouncing, then slower toggling with occasional resets
    for (int k = 0; k < 600; k++) begin
      tmask = '0;
      for (int b = 0; b < W; b++) tmask[b] = ($urandom_range(0, 3) == 0);
      sw_raw = sw_raw ^ tmask;
      step("rnd_fast");
    end
    rst_left = 0;
    for (int k = 0; k < 3000; k++) begin
      tmask = '0;
      for (int b = 0; b < W; b++) tmask[b] = ($urandom_range(0, 14) == 0);
      sw_raw = sw_raw ^ tmask;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        reset_n = 1'b0;
        model_reset();
        rst_left = 2;
      end
      step("rnd_slow");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
